// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares one single-port, 1-cycle synchronous-read data memory between two
//   requesters (port 0 = CPU load/store unit, port 1 = DMA/debug master).
//   Every access is sequenced by a three-state FSM (IDLE, RD, RMW).
//   Because the memory has no byte enables, byte and halfword stores become
//   read-modify-write. Misaligned accesses are answered with an error and
//   never touch memory.
//
// Ports
//   clk, rst                     clock, synchronous active-high reset
//   pN_req_valid/ready           request handshake (N = 0, 1)
//   pN_req_addr/we/size/wdata    byte address, store flag, size (00 B, 01 H,
//                                10/11 W), right-aligned store data
//   pN_rsp_valid/rdata/err       one-cycle response pulse, full aligned word,
//                                misaligned flag
//   mem_addr/wdata/we/re         memory command
//   mem_rdata                    memory read data, valid the cycle after mem_re
//
// Configuration
//   DMEM_ARB_ROUND_ROBIN_EN  defined: round-robin between the ports using a
//                            last_grant register (port 0 wins first).
//                            undefined: fixed priority, port 0 wins.

module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_req_valid,
  output logic              p0_req_ready,
  input  logic [ADDR_W-1:0] p0_req_addr,
  input  logic              p0_req_we,
  input  logic [1:0]        p0_req_size,
  input  logic [DATA_W-1:0] p0_req_wdata,
  output logic              p0_rsp_valid,
  output logic [DATA_W-1:0] p0_rsp_rdata,
  output logic              p0_rsp_err,
  input  logic              p1_req_valid,
  output logic              p1_req_ready,
  input  logic [ADDR_W-1:0] p1_req_addr,
  input  logic              p1_req_we,
  input  logic [1:0]        p1_req_size,
  input  logic [DATA_W-1:0] p1_req_wdata,
  output logic              p1_rsp_valid,
  output logic [DATA_W-1:0] p1_rsp_rdata,
  output logic              p1_rsp_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, RMW} state_t;

  state_t state_reg, state_next;

  // Arbitration and the selected request
  logic              grant;
  logic              any_valid;
  logic              handshake;
  logic [ADDR_W-1:0] sel_addr;
  logic              sel_we;
  logic [1:0]        sel_size;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_misaligned;

  // Request held across RD/RMW
  logic              port_reg;
  logic              rmw_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [1:0]        size_reg;
  logic [15:0]       wdata_reg;
  logic              capture;

  // Registered acks/errors, one-hot by port
  logic [1:0]        rsp_valid_reg, rsp_valid_next;
  logic              rsp_err_reg, rsp_err_next;

  logic [DATA_W-1:0] merged;
  logic              rd_load;

  assign any_valid = p0_req_valid | p1_req_valid;
  assign handshake = (state_reg == IDLE) && !rst && any_valid;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // Under contention the port that did not win last time goes next.
  always_comb begin
    if (p0_req_valid && p1_req_valid) begin
      grant = ~last_grant_reg;
    end else begin
      grant = ~p0_req_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (handshake) begin
      last_grant_reg <= grant;
    end
  end
`else
  // Port 0 wins whenever it is valid.
  assign grant = ~p0_req_valid;
`endif

  assign p0_req_ready = (state_reg == IDLE) && !rst && p0_req_valid && !grant;
  assign p1_req_ready = (state_reg == IDLE) && !rst && p1_req_valid && grant;

  assign sel_addr  = grant ? p1_req_addr  : p0_req_addr;
  assign sel_we    = grant ? p1_req_we    : p0_req_we;
  assign sel_size  = grant ? p1_req_size  : p0_req_size;
  assign sel_wdata = grant ? p1_req_wdata : p0_req_wdata;

  always_comb begin
    case (sel_size)
      2'b00:   sel_misaligned = 1'b0;
      2'b01:   sel_misaligned = sel_addr[0];
      default: sel_misaligned = (sel_addr[1:0] != 2'b00);
    endcase
  end

  // Lane merge for the write half of a read-modify-write: the addressed byte
  // or halfword comes from the held store data, every other lane from memory.
  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    logic byte_hit;
    logic half_hit;
    assign byte_hit = (size_reg == 2'b00) && (addr_reg[1:0] == 2'(gi));
    assign half_hit = (size_reg == 2'b01) && (addr_reg[1] == 1'(gi / 2));
    assign merged[8*gi +: 8] = byte_hit ? wdata_reg[7:0] :
                               half_hit ? wdata_reg[8*(gi % 2) +: 8] :
                                          mem_rdata[8*gi +: 8];
  end

  always_comb begin
    state_next     = state_reg;
    mem_we         = 1'b0;
    mem_re         = 1'b0;
    mem_addr       = '0;
    mem_wdata      = '0;
    rsp_valid_next = 2'b00;
    rsp_err_next   = 1'b0;
    capture        = 1'b0;
    case (state_reg)
      IDLE: begin
        if (handshake) begin
          if (sel_misaligned) begin
            rsp_valid_next = grant ? 2'b10 : 2'b01;
            rsp_err_next   = 1'b1;
          end else if (sel_we && sel_size[1]) begin
            // Full-word store goes straight to memory; ack next cycle.
            mem_we         = 1'b1;
            mem_addr       = sel_addr;
            mem_wdata      = sel_wdata;
            rsp_valid_next = grant ? 2'b10 : 2'b01;
          end else begin
            // Load, or the read half of a sub-word store.
            mem_re     = 1'b1;
            mem_addr   = sel_addr;
            capture    = 1'b1;
            state_next = RD;
          end
        end
      end
      RD: begin
        if (rmw_reg) begin
          mem_we         = 1'b1;
          mem_addr       = addr_reg;
          mem_wdata      = merged;
          rsp_valid_next = port_reg ? 2'b10 : 2'b01;
          state_next     = RMW;
        end else begin
          state_next = IDLE;
        end
      end
      RMW: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    // Nothing reaches memory while reset is held, so an interrupted RMW
    // cannot write a half-merged word.
    if (rst) begin
      mem_we    = 1'b0;
      mem_re    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      port_reg      <= 1'b0;
      rmw_reg       <= 1'b0;
      addr_reg      <= '0;
      size_reg      <= 2'b00;
      wdata_reg     <= '0;
      rsp_valid_reg <= 2'b00;
      rsp_err_reg   <= 1'b0;
    end else begin
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      if (capture) begin
        port_reg  <= grant;
        rmw_reg   <= sel_we;
        addr_reg  <= sel_addr;
        size_reg  <= sel_size;
        wdata_reg <= sel_wdata[15:0];
      end
    end
  end

  // Load data is passed straight through from memory in the RD cycle.
  assign rd_load = (state_reg == RD) && !rmw_reg && !rst;

  assign p0_rsp_valid = !rst && (rsp_valid_reg[0] || (rd_load && !port_reg));
  assign p1_rsp_valid = !rst && (rsp_valid_reg[1] || (rd_load && port_reg));
  assign p0_rsp_err   = !rst && rsp_valid_reg[0] && rsp_err_reg;
  assign p1_rsp_err   = !rst && rsp_valid_reg[1] && rsp_err_reg;
  assign p0_rsp_rdata = (rd_load && !port_reg) ? mem_rdata : '0;
  assign p1_rsp_rdata = (rd_load && port_reg) ? mem_rdata : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Testbench for dmem_arbiter: directed scenarios plus randomized two-port
// traffic against a word-array reference model and a small memory model.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        p0_req_valid = 1'b0, p1_req_valid = 1'b0;
  logic        p0_req_ready, p1_req_ready;
  logic [31:0] p0_req_addr = '0, p1_req_addr = '0;
  logic        p0_req_we = 1'b0, p1_req_we = 1'b0;
  logic [1:0]  p0_req_size = '0, p1_req_size = '0;
  logic [31:0] p0_req_wdata = '0, p1_req_wdata = '0;
  logic        p0_rsp_valid, p1_rsp_valid;
  logic [31:0] p0_rsp_rdata, p1_rsp_rdata;
  logic        p0_rsp_err, p1_rsp_err;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_we, mem_re;
  logic [31:0] mem_rdata = '0;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .p0_req_valid(p0_req_valid), .p0_req_ready(p0_req_ready),
    .p0_req_addr(p0_req_addr), .p0_req_we(p0_req_we),
    .p0_req_size(p0_req_size), .p0_req_wdata(p0_req_wdata),
    .p0_rsp_valid(p0_rsp_valid), .p0_rsp_rdata(p0_rsp_rdata),
    .p0_rsp_err(p0_rsp_err),
    .p1_req_valid(p1_req_valid), .p1_req_ready(p1_req_ready),
    .p1_req_addr(p1_req_addr), .p1_req_we(p1_req_we),
    .p1_req_size(p1_req_size), .p1_req_wdata(p1_req_wdata),
    .p1_rsp_valid(p1_rsp_valid), .p1_rsp_rdata(p1_rsp_rdata),
    .p1_rsp_err(p1_rsp_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // 16-word memory behind the arbiter, 1-cycle registered read.
  logic [31:0] tb_mem [16];
  always @(posedge clk) begin
    if (mem_we) tb_mem[mem_addr[5:2]] <= mem_wdata;
    if (mem_re) mem_rdata <= tb_mem[mem_addr[5:2]];
  end

  // Reference model state
  logic [31:0] ref_mem [16];
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          due;
  } exp_t;
  exp_t q0[$];
  exp_t q1[$];
  int   grant_log[$];
  bit   model_en = 1'b1;

  int compared = 0;
  int mismatched = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected response of an accepted request, from the access rules alone.
  task automatic accept(input int p, input logic [31:0] a, input logic we,
                        input logic [1:0] sz, input logic [31:0] wd, input int c);
    exp_t e;
    int idx;
    int sh;
    logic mis;
    grant_log.push_back(p);
    if (!model_en) return;
    idx = a[5:2];
    mis = (sz == 2'b01 && a[0]) || (sz[1] && a[1:0] != 2'b00);
    e.rdata = '0;
    e.err = 1'b0;
    e.due = c + 1;
    if (mis) begin
      e.err = 1'b1;
    end else if (!we) begin
      e.rdata = ref_mem[idx];
    end else if (sz[1]) begin
      ref_mem[idx] = wd;
    end else begin
      if (sz == 2'b00) begin
        sh = 8 * a[1:0];
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFF << sh)) | ((wd & 32'hFF) << sh);
      end else begin
        sh = 16 * a[1];
        ref_mem[idx] = (ref_mem[idx] & ~(32'hFFFF << sh)) | ((wd & 32'hFFFF) << sh);
      end
      e.due = c + 2;
    end
    $display("req p%0d addr=0x%02h we=%0d size=%0d wdata=0x%08h -> exp rdata=0x%08h err=%0d",
             p, a[7:0], we, sz, wd, e.rdata, e.err);
    if (p == 0) q0.push_back(e);
    else q1.push_back(e);
  endtask

  task automatic drive(input int p, input logic v, input logic [31:0] a,
                       input logic we, input logic [1:0] sz, input logic [31:0] wd);
    if (p == 0) begin
      p0_req_valid = v; p0_req_addr = a; p0_req_we = we; p0_req_size = sz; p0_req_wdata = wd;
    end else begin
      p1_req_valid = v; p1_req_addr = a; p1_req_we = we; p1_req_size = sz; p1_req_wdata = wd;
    end
  endtask

  // Present a request and hold it until accepted (valid stays high afterwards).
  task automatic issue(input int p, input logic [31:0] a, input logic we,
                       input logic [1:0] sz, input logic [31:0] wd);
    int waited;
    logic hs;
    int c;
    waited = 0;
    @(negedge clk);
    drive(p, 1'b1, a, we, sz, wd);
    forever begin
      #1;
      hs = (p == 0) ? (p0_req_valid && p0_req_ready) : (p1_req_valid && p1_req_ready);
      c = cyc;
      @(posedge clk);
      if (hs) begin
        accept(p, a, we, sz, wd, c);
        break;
      end
      waited++;
      if (waited > 2000) begin
        chk($sformatf("p%0d accept timeout", p), 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic release_port(input int p);
    @(negedge clk);
    drive(p, 1'b0, '0, 1'b0, 2'b00, '0);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("responses outstanding", q0.size() + q1.size(), 0);
  endtask

  // Scoreboard monitor
  task automatic check_rsp(input int p, input logic [31:0] rd, input logic err);
    exp_t e;
    if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
      chk($sformatf("p%0d spurious rsp_valid", p), 32'd1, 32'd0);
      return;
    end
    e = (p == 0) ? q0.pop_front() : q1.pop_front();
    $display("rsp p%0d rdata=0x%08h err=%0d cycle=%0d", p, rd, err, cyc);
    chk($sformatf("p%0d rsp_rdata", p), rd, e.rdata);
    chk($sformatf("p%0d rsp_err", p), 32'(err), 32'(e.err));
    chk($sformatf("p%0d rsp cycle", p), cyc, e.due);
  endtask

  always @(negedge clk) begin
    if (p0_rsp_valid) check_rsp(0, p0_rsp_rdata, p0_rsp_err);
    if (p1_rsp_valid) check_rsp(1, p1_rsp_rdata, p1_rsp_err);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_order[6];
    int busy;
    for (int i = 0; i < 16; i++) begin
      tb_mem[i] = 32'h0101_0101 * i + 32'hA000_0000;
      ref_mem[i] = tb_mem[i];
    end
    tb_mem[8] = 32'h1122_3344;
    ref_mem[8] = 32'h1122_3344;

    // Reset state, with both ports requesting
    drive(0, 1'b1, 32'h4, 1'b0, 2'b10, '0);
    drive(1, 1'b1, 32'h8, 1'b0, 2'b10, '0);
    repeat (3) begin
      @(negedge clk);
      chk("reset p0_req_ready", 32'(p0_req_ready), 0);
      chk("reset p1_req_ready", 32'(p1_req_ready), 0);
      chk("reset mem_we/mem_re", {30'd0, mem_we, mem_re}, 0);
      chk("reset rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 0);
    end
    drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
    drive(1, 1'b0, '0, 1'b0, 2'b00, '0);
    rst = 1'b0;

    // Contention: both ports hold three back-to-back loads
    grant_log.delete();
    fork
      begin
        for (int i = 0; i < 3; i++) issue(0, 32'(4 * i), 1'b0, 2'b10, '0);
        release_port(0);
      end
      begin
        for (int i = 0; i < 3; i++) issue(1, 32'(4 * i + 16), 1'b0, 2'b10, '0);
        release_port(1);
      end
    join
    drain();
`ifdef DMEM_ARB_ROUND_ROBIN_EN
    exp_order = '{0, 1, 0, 1, 0, 1};
`else
    exp_order = '{0, 0, 0, 1, 1, 1};
`endif
    for (int i = 0; i < 6; i++) begin
      chk($sformatf("grant order[%0d]", i),
          (i < grant_log.size()) ? 32'(grant_log[i]) : 32'hFFFF_FFFF, 32'(exp_order[i]));
    end

    // Word store then load
    issue(0, 32'h10, 1'b1, 2'b10, 32'hDEAD_BEEF);
    issue(0, 32'h10, 1'b0, 2'b10, '0);
    release_port(0);
    drain();

    // Byte RMW then load-back
    issue(1, 32'h22, 1'b1, 2'b00, 32'h0000_00AA);
    release_port(1);
    issue(0, 32'h20, 1'b0, 2'b10, '0);
    release_port(0);
    drain();
    chk("byte rmw memory word", tb_mem[8], 32'h11AA_3344);

    // Half RMW
    issue(0, 32'h20, 1'b1, 2'b10, 32'h1122_3344);
    issue(0, 32'h22, 1'b1, 2'b01, 32'h0000_BEEF);
    issue(0, 32'h20, 1'b0, 2'b10, '0);
    release_port(0);
    drain();
    chk("half rmw memory word", tb_mem[8], 32'hBEEF_3344);

    // Misaligned on both ports; memory must stay idle throughout
    busy = 0;
    fork
      begin issue(0, 32'h13, 1'b0, 2'b10, '0); release_port(0); end
      begin issue(1, 32'h21, 1'b1, 2'b01, 32'h1234); release_port(1); end
      begin
        repeat (8) begin
          @(negedge clk);
          if (mem_we || mem_re) busy++;
        end
      end
    join
    drain();
    chk("misaligned memory activity", busy, 0);

    // Randomized traffic from both ports
    fork
      for (int pp = 0; pp < 2; pp++) begin
        automatic int p = pp;
        begin
          for (int n = 0; n < 60; n++) begin
            issue(p, 32'($urandom_range(0, 63)), 1'($urandom_range(0, 1)),
                  2'($urandom_range(0, 3)), $urandom);
            if ($urandom_range(0, 1) == 0) begin
              release_port(p);
              repeat ($urandom_range(1, 3)) @(negedge clk);
            end
          end
          release_port(p);
        end
      end
    join
    drain();

    // Reset during the RD cycle of a byte store
    model_en = 1'b0;
    issue(0, 32'h31, 1'b1, 2'b00, 32'h0000_005A);
    #1;
    rst = 1'b1;
    drive(0, 1'b0, '0, 1'b0, 2'b00, '0);
    drive(1, 1'b1, 32'h30, 1'b0, 2'b10, '0);
    repeat (2) begin
      @(negedge clk);
      chk("mid-rmw reset mem_we", 32'(mem_we), 0);
      chk("mid-rmw reset ready", {30'd0, p0_req_ready, p1_req_ready}, 0);
      chk("mid-rmw reset rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 0);
    end
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1'b0, '0, 1'b0, 2'b00, '0);
    model_en = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post-reset mem_we", 32'(mem_we), 0);
      chk("post-reset rsp_valid", {30'd0, p0_rsp_valid, p1_rsp_valid}, 0);
    end
    issue(0, 32'h30, 1'b0, 2'b10, '0);
    release_port(0);
    drain();

    for (int i = 0; i < 16; i++) begin
      chk($sformatf("final memory[%0d]", i), tb_mem[i], ref_mem[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
